// File: rtl/cont_status_datapath_pkg.sv
// ---------------------------------------------------------------------------
// cont_status_datapath_pkg
// Purpose : Shared definitions between the status datapath and its one-hot
//           controller: control-point bit positions and a decoded view of
//           the control word.
// Contents: CP_W, CP_* bit indices, cp_t decoded struct, decode_cp().
// ---------------------------------------------------------------------------
package cont_status_datapath_pkg;

    localparam int CP_W       = 5;
    localparam int CP_ACC_EN  = 4;
    localparam int CP_OP_SEL  = 3;
    localparam int CP_SUB     = 2;
    localparam int CP_LOAD_B  = 1;
    localparam int CP_FLAG_EN = 0;

    typedef struct packed {
        logic acc_en;
        logic op_sel;
        logic sub;
        logic load_b;
        logic flag_en;
    } cp_t;

    function automatic cp_t decode_cp(input logic [CP_W-1:0] cp);
        cp_t d;
        d.acc_en  = cp[CP_ACC_EN];
        d.op_sel  = cp[CP_OP_SEL];
        d.sub     = cp[CP_SUB];
        d.load_b  = cp[CP_LOAD_B];
        d.flag_en = cp[CP_FLAG_EN];
        return d;
    endfunction

endpackage

// File: rtl/cont_operand_buffer.sv
// ---------------------------------------------------------------------------
// cont_operand_buffer
// Purpose : One-entry valid/ready input buffer feeding the B operand
//           register, with a sticky underrun flag.
// Ports   : clk       - system clock
//           clr       - asynchronous active-low clear
//           din       - operand data from producer
//           din_valid - din valid this cycle
//           load_b    - controller request to move the buffer into B
//           din_ready - buffer can accept din this cycle (combinational)
//           b         - B operand register
//           underrun  - sticky: load_b seen while the buffer was empty
// ---------------------------------------------------------------------------
module cont_operand_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             load_b,
    output logic             din_ready,
    output logic [WIDTH-1:0] b,
    output logic             underrun
);

    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic             xfer;
    logic [WIDTH-1:0] b_q;
    logic             underrun_q;

    // A full buffer that is being drained this cycle can take new data.
    assign din_ready = ~buf_full | load_b;
    assign xfer      = din_valid & din_ready;

    // ---- stage boundary: buffer, B and underrun registers ----
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            buf_data   <= '0;
            buf_full   <= 1'b0;
            b_q        <= '0;
            underrun_q <= 1'b0;
        end else begin
            // An empty-buffer load is never bypassed from din into B.
            if (load_b) begin
                if (buf_full) begin
                    b_q <= buf_data;
                end else begin
                    underrun_q <= 1'b1;
                end
            end
            if (xfer) begin
                buf_data <= din;
                buf_full <= 1'b1;
            end else if (load_b) begin
                buf_full <= 1'b0;
            end
        end
    end

    assign b        = b_q;
    assign underrun = underrun_q;

endmodule

// File: rtl/cont_status_datapath.sv
// ---------------------------------------------------------------------------
// cont_status_datapath
// Purpose : Accumulator datapath driven by a one-hot controller. Adds or
//           subtracts B (or constant 1) to/from the accumulator and
//           produces registered V (signed overflow) and Z (zero) flags.
// Ports   : clk       - system clock
//           clr       - asynchronous active-low clear of all state
//           cp[4:0]   - control points {ACC_EN, OP_SEL, SUB, LOAD_B, FLAG_EN}
//           din       - operand data from producer
//           din_valid - din valid this cycle
//           din_ready - datapath can accept din this cycle
//           V         - registered signed-overflow flag
//           Z         - registered zero flag
//           acc       - accumulator value
//           underrun  - sticky LOAD_B-with-empty-buffer error
// ---------------------------------------------------------------------------
module cont_status_datapath
    import cont_status_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CP_W-1:0]  cp,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             V,
    output logic             Z,
    output logic [WIDTH-1:0] acc,
    output logic             underrun
);

    localparam logic signed [WIDTH-1:0] ONE_OP = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement overflow: for add, both operands share a sign that
    // the result lost; for subtract, the operands differ in sign and the
    // result's sign departs from the minuend.
    function automatic logic sgn_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] o,
                                     input logic signed [WIDTH-1:0] r,
                                     input logic                    sub);
        logic sa, so, sr;
        sa = a[WIDTH-1];
        so = o[WIDTH-1];
        sr = r[WIDTH-1];
        if (sub) begin
            return (sa != so) && (sr != sa);
        end
        return (sa == so) && (sr != sa);
    endfunction

    cp_t                     ctl;
    logic signed [WIDTH-1:0] b_p1;
    logic signed [WIDTH-1:0] acc_p1;
    logic                    v_p1;
    logic                    z_p1;
    logic signed [WIDTH-1:0] operand_p0;
    logic signed [WIDTH-1:0] result_p0;
    logic                    ovf_p0;

    assign ctl = decode_cp(cp);

    cont_operand_buffer #(
        .WIDTH     (WIDTH)
    ) u_buffer (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_valid (din_valid),
        .load_b    (ctl.load_b),
        .din_ready (din_ready),
        .b         (b_p1),
        .underrun  (underrun)
    );

    // ---- stage p0: combinational ALU on pre-edge acc and B ----
    assign operand_p0 = ctl.op_sel ? ONE_OP : b_p1;
    assign result_p0  = ctl.sub ? (acc_p1 - operand_p0) : (acc_p1 + operand_p0);
    assign ovf_p0     = sgn_ovf(acc_p1, operand_p0, result_p0, ctl.sub);

    // ---- stage p1: accumulator and flag registers ----
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_p1 <= '0;
            v_p1   <= 1'b0;
            z_p1   <= 1'b0;
        end else begin
            if (ctl.acc_en) begin
                acc_p1 <= result_p0;
            end
            if (ctl.flag_en) begin
                z_p1 <= (result_p0 == '0);
                v_p1 <= ovf_p0;
            end
        end
    end

    assign acc = acc_p1;
    assign V   = v_p1;
    assign Z   = z_p1;

endmodule
